// File: rtl/const_ext_regs.sv
// -----------------------------------------------------------------------------
// const_ext_regs
//   Decode-stage helper slice for the 4-stage RISC pipeline (IF/DOF/EX/WB).
//   - Extends the instruction immediate to 32 bits (sign or zero) for
//     operand mux B, combinationally and with zero latency.
//   - Holds load-enabled 1-bit and 2-bit pipeline flag registers plus a
//     registered copy of the extended constant.
//
//   Optional feature macro: CONST_EXT_FLUSH_EN
//     defined   -> adds input 'flush'; a rising clk with flush=1 returns every
//                  register to RST_VAL, overriding load (bubble insertion on
//                  taken branches). const_out is never affected by flush.
//     undefined -> no flush port; registers follow load/hold only.
// -----------------------------------------------------------------------------
module const_ext_regs #(
  parameter int IMM_W   = 15,   // immediate width; target width is fixed at 32
  parameter bit RST_VAL = 1'b0  // reset/flush value replicated into every bit
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [IMM_W-1:0] imm,
  input  logic             cs,
  input  logic             d1,
  input  logic [1:0]       d2,
`ifdef CONST_EXT_FLUSH_EN
  input  logic             flush,
`endif
  output logic [31:0]      const_out,
  output logic [31:0]      const_q,
  output logic             q1,
  output logic [1:0]       q2
);

  localparam int EXT_W = 32 - IMM_W;

  // Every register clears to the same replicated value on reset and on flush.
  localparam logic [31:0] CONST_CLR = {32{RST_VAL}};
  localparam logic [1:0]  D2_CLR    = {2{RST_VAL}};
  localparam logic        D1_CLR    = RST_VAL;

  logic        flush_i;
  logic        fill_bit;
  logic [31:0] ext_c;

`ifdef CONST_EXT_FLUSH_EN
  assign flush_i = flush;
`else
  // Without the feature the flush path is tied off and optimised away.
  assign flush_i = 1'b0;
`endif

  // Extension: the upper bits copy the immediate MSB only when sign-extending.
  // ANDing with cs (rather than a mux on cs) keeps the fill bit a clean 0/1
  // whenever cs and imm are known, so const_out never goes X.
  always_comb begin
    fill_bit  = cs & imm[IMM_W-1];
    ext_c     = {{EXT_W{fill_bit}}, imm};
    const_out = ext_c;
  end

  // Pipeline registers: async clear, then flush over load over hold.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1      <= D1_CLR;
      q2      <= D2_CLR;
      const_q <= CONST_CLR;
    end else if (flush_i) begin
      q1      <= D1_CLR;
      q2      <= D2_CLR;
      const_q <= CONST_CLR;
    end else if (load) begin
      q1      <= d1;
      q2      <= d2;
      const_q <= ext_c;
    end
  end

endmodule

// File: tb/tb_const_ext_regs.sv
// -----------------------------------------------------------------------------
// tb_const_ext_regs
//   Self-checking bench for const_ext_regs. A behavioural model (signed integer
//   arithmetic for the extension, plain variables for the registers) predicts
//   every output. Build with +define+CONST_EXT_FLUSH_EN to cover flush.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_const_ext_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [14:0] imm;
  logic        cs;
  logic        d1;
  logic [1:0]  d2;
`ifdef CONST_EXT_FLUSH_EN
  logic        flush;
`endif
  logic [31:0] const_out;
  logic [31:0] const_q;
  logic        q1;
  logic [1:0]  q2;

  // Reference state
  logic        m_q1;
  logic [1:0]  m_q2;
  logic [31:0] m_cq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  const_ext_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .imm       (imm),
    .cs        (cs),
    .d1        (d1),
    .d2        (d2),
`ifdef CONST_EXT_FLUSH_EN
    .flush     (flush),
`endif
    .const_out (const_out),
    .const_q   (const_q),
    .q1        (q1),
    .q2        (q2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Extension as a number: a 15-bit field read as two's complement when cs=1.
  function automatic logic [31:0] ext_model(input logic [14:0] i, input logic c);
    int v;
    v = int'(i);
    if (c && v >= 16384) v = v - 32768;
    return 32'(v);
  endfunction

  task automatic model_clear();
    m_q1 = 1'b0;
    m_q2 = 2'b00;
    m_cq = 32'h0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_q1"}, {31'b0, q1}, {31'b0, m_q1});
    check({tag, "_q2"}, {30'b0, q2}, {30'b0, m_q2});
    check({tag, "_cq"}, const_q, m_cq);
  endtask

  // Predict the edge from current inputs, take one rising edge, check after it.
  task automatic clock_step(input string tag);
    logic fl;
    fl = 1'b0;
`ifdef CONST_EXT_FLUSH_EN
    fl = flush;
`endif
    if (fl) model_clear();
    else if (load) begin
      m_q1 = d1;
      m_q2 = d2;
      m_cq = ext_model(imm, cs);
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  logic [14:0] sweep [4];

  initial begin
    // Test 1: reset asserted with active inputs, no clock edge yet
    rst_n = 1'b0; load = 1'b1; d1 = 1'b1; d2 = 2'd3; imm = 15'h0; cs = 1'b0;
`ifdef CONST_EXT_FLUSH_EN
    flush = 1'b0;
`endif
    #2;
    model_clear();
    check_regs("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Test 2: extension of 0x4001 and registering it
    imm = 15'h4001; cs = 1'b1; #1;
    check("ext_4001_s", const_out, 32'hFFFF_C001);
    cs = 1'b0; #1;
    check("ext_4001_z", const_out, 32'h0000_4001);
    cs = 1'b1; load = 1'b1;
    clock_step("cap_4001");
    check("cq_4001", const_q, 32'hFFFF_C001);

    // Test 3: load then hold
    load = 1'b1; d1 = 1'b1; d2 = 2'd2;
    clock_step("load_12");
    check("load_q2_val", {30'b0, q2}, 32'd2);
    load = 1'b0; d1 = 1'b0; d2 = 2'd1;
    clock_step("hold_12");
    check("hold_q2_val", {30'b0, q2}, 32'd2);

    // Test 4: asynchronous reset between edges, then recapture
    load = 1'b1; d2 = 2'd3;
    clock_step("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_regs("async_rst");
    check("async_rst_q2", {30'b0, q2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; load = 1'b1; d2 = 2'd1;
    clock_step("post_rst");
    check("post_rst_q2", {30'b0, q2}, 32'd1);

`ifdef CONST_EXT_FLUSH_EN
    // Test 5: flush overrides load, const_out untouched
    load = 1'b1; d2 = 2'd2;
    clock_step("pre_flush");
    flush = 1'b1; d2 = 2'd3; imm = 15'h7FFF; cs = 1'b1; #1;
    check("flush_comb", const_out, 32'hFFFF_FFFF);
    clock_step("flush");
    check("flush_q2", {30'b0, q2}, 32'd0);
    flush = 1'b0;
    clock_step("unflush");
    check("unflush_q2", {30'b0, q2}, 32'd3);
`endif

    // Test 6: boundary sweep for both extension modes
    sweep[0] = 15'h0000; sweep[1] = 15'h3FFF; sweep[2] = 15'h4000; sweep[3] = 15'h7FFF;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 2; c++) begin
        imm = sweep[i]; cs = c[0]; #1;
        check($sformatf("sweep_%h_cs%0d", sweep[i], c), const_out, ext_model(imm, cs));
      end
    end
    imm = 15'h4000; cs = 1'b1; #1;
    check("bnd_4000_s", const_out, 32'hFFFF_C000);
    cs = 1'b0; #1;
    check("bnd_4000_z", const_out, 32'h0000_4000);
    imm = 15'h7FFF; cs = 1'b1; #1;
    check("bnd_7fff_s", const_out, 32'hFFFF_FFFF);

    // Randomised traffic with occasional mid-cycle resets
    for (int n = 0; n < 300; n++) begin
      load = ($urandom_range(0, 3) != 0);
      d1   = 1'($urandom);
      d2   = 2'($urandom);
      imm  = 15'($urandom);
      cs   = 1'($urandom);
`ifdef CONST_EXT_FLUSH_EN
      flush = ($urandom_range(0, 9) == 0);
`endif
      #1;
      check("rnd_comb", const_out, ext_model(imm, cs));
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        #1;
        model_clear();
        check_regs("rnd_rst");
        rst_n = 1'b1;
      end
      clock_step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety bound so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
